// File: rtl/rob_pkg.sv
// Shared reorder-buffer types used by rename, dispatch and retire.
// Entry layout is fixed by the default register-index widths below.
package rob_pkg;

    localparam int DEF_AREG_W = 5;
    localparam int DEF_PREG_W = 6;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_rd;
        logic [DEF_AREG_W-1:0] rd;
        logic [DEF_PREG_W-1:0] pd;
        logic [DEF_PREG_W-1:0] old_pd;
        logic [31:0]           value;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire.sv
// Reorder buffer with in-order retire: allocates at tail, marks completions,
// retires the head entry once done and releases its previous physical mapping.
module rob_retire
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AREG_W = DEF_AREG_W,
    parameter int PREG_W = DEF_PREG_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_rd,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic [PREG_W-1:0] alloc_pd,
    input  logic [PREG_W-1:0] alloc_old_pd,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_idx,
    input  logic [31:0]       cmpl_value,
    output logic              ret_valid,
    output logic              ret_has_rd,
    output logic [AREG_W-1:0] ret_rd,
    output logic [PREG_W-1:0] ret_pd,
    output logic [31:0]       ret_value,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_pd,
    output logic [IDX_W:0]    count,
    output logic              cmpl_err
);

    rob_entry_t        rob_q [DEPTH];
    rob_entry_t        rob_d [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              cmpl_err_q, cmpl_err_d;
    logic              ret_valid_q, ret_valid_d;
    logic              ret_has_rd_q, ret_has_rd_d;
    logic [AREG_W-1:0] ret_rd_q, ret_rd_d;
    logic [PREG_W-1:0] ret_pd_q, ret_pd_d;
    logic [31:0]       ret_value_q, ret_value_d;
    logic              free_valid_q, free_valid_d;
    logic [PREG_W-1:0] free_pd_q, free_pd_d;
    logic              do_alloc, do_retire, cmpl_ok;

    always_comb begin
        rob_d        = rob_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        cmpl_err_d   = cmpl_err_q;
        ret_valid_d  = 1'b0;
        ret_has_rd_d = ret_has_rd_q;
        ret_rd_d     = ret_rd_q;
        ret_pd_d     = ret_pd_q;
        ret_value_d  = ret_value_q;
        free_valid_d = 1'b0;
        free_pd_d    = free_pd_q;

        // Readiness comes from the registered count only; a retire this cycle frees a slot next cycle.
        alloc_ready = (count_q != (IDX_W+1)'(DEPTH));
        do_alloc    = alloc_valid && alloc_ready;
        do_retire   = rob_q[head_q].valid && rob_q[head_q].done;
        cmpl_ok     = rob_q[cmpl_idx].valid && !rob_q[cmpl_idx].done;

        if (do_retire) begin
            rob_d[head_q].valid = 1'b0;
            rob_d[head_q].done  = 1'b0;
            head_d       = head_q + IDX_W'(1);
            ret_valid_d  = 1'b1;
            ret_has_rd_d = rob_q[head_q].has_rd;
            ret_rd_d     = AREG_W'(rob_q[head_q].rd);
            ret_pd_d     = PREG_W'(rob_q[head_q].pd);
            ret_value_d  = rob_q[head_q].value;
            free_valid_d = rob_q[head_q].has_rd;
            free_pd_d    = PREG_W'(rob_q[head_q].old_pd);
        end

        if (cmpl_valid) begin
            if (cmpl_ok) begin
                rob_d[cmpl_idx].done  = 1'b1;
                rob_d[cmpl_idx].value = cmpl_value;
            end else begin
                cmpl_err_d = 1'b1;
            end
        end

        // The tail slot is never the head of a live retire nor a legal completion target.
        if (do_alloc) begin
            rob_d[tail_q].valid  = 1'b1;
            rob_d[tail_q].done   = 1'b0;
            rob_d[tail_q].has_rd = alloc_has_rd && (alloc_rd != '0);
            rob_d[tail_q].rd     = DEF_AREG_W'(alloc_rd);
            rob_d[tail_q].pd     = DEF_PREG_W'(alloc_pd);
            rob_d[tail_q].old_pd = DEF_PREG_W'(alloc_old_pd);
            rob_d[tail_q].value  = '0;
            tail_d = tail_q + IDX_W'(1);
        end

        case ({do_alloc, do_retire})
            2'b10:   count_d = count_q + (IDX_W+1)'(1);
            2'b01:   count_d = count_q - (IDX_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cmpl_err_q   <= 1'b0;
            ret_valid_q  <= 1'b0;
            ret_has_rd_q <= 1'b0;
            ret_rd_q     <= '0;
            ret_pd_q     <= '0;
            ret_value_q  <= '0;
            free_valid_q <= 1'b0;
            free_pd_q    <= '0;
        end else begin
            rob_q        <= rob_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            cmpl_err_q   <= cmpl_err_d;
            ret_valid_q  <= ret_valid_d;
            ret_has_rd_q <= ret_has_rd_d;
            ret_rd_q     <= ret_rd_d;
            ret_pd_q     <= ret_pd_d;
            ret_value_q  <= ret_value_d;
            free_valid_q <= free_valid_d;
            free_pd_q    <= free_pd_d;
        end
    end

    assign alloc_idx  = tail_q;
    assign count      = count_q;
    assign cmpl_err   = cmpl_err_q;
    assign ret_valid  = ret_valid_q;
    assign ret_has_rd = ret_has_rd_q;
    assign ret_rd     = ret_rd_q;
    assign ret_pd     = ret_pd_q;
    assign ret_value  = ret_value_q;
    assign free_valid = free_valid_q;
    assign free_pd    = free_pd_q;

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: a program-order queue model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_rob_retire;

    localparam int DEPTH  = 16;
    localparam int AREG_W = 5;
    localparam int PREG_W = 6;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic              alloc_has_rd = 1'b0;
    logic [AREG_W-1:0] alloc_rd = '0;
    logic [PREG_W-1:0] alloc_pd = '0;
    logic [PREG_W-1:0] alloc_old_pd = '0;
    logic [IDX_W-1:0]  alloc_idx;
    logic              cmpl_valid = 1'b0;
    logic [IDX_W-1:0]  cmpl_idx = '0;
    logic [31:0]       cmpl_value = '0;
    logic              ret_valid;
    logic              ret_has_rd;
    logic [AREG_W-1:0] ret_rd;
    logic [PREG_W-1:0] ret_pd;
    logic [31:0]       ret_value;
    logic              free_valid;
    logic [PREG_W-1:0] free_pd;
    logic [IDX_W:0]    count;
    logic              cmpl_err;

    rob_retire #(.DEPTH(DEPTH), .AREG_W(AREG_W), .PREG_W(PREG_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_has_rd(alloc_has_rd),
        .alloc_rd(alloc_rd), .alloc_pd(alloc_pd), .alloc_old_pd(alloc_old_pd),
        .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_value(cmpl_value),
        .ret_valid(ret_valid), .ret_has_rd(ret_has_rd), .ret_rd(ret_rd), .ret_pd(ret_pd),
        .ret_value(ret_value), .free_valid(free_valid), .free_pd(free_pd),
        .count(count), .cmpl_err(cmpl_err)
    );

    always #5 clk = ~clk;

    // In-flight instructions in program order; index 0 is the oldest.
    typedef struct {
        int          tag;
        bit          has_rd;
        int          rd;
        int          pd;
        int          old_pd;
        bit          done;
        int unsigned value;
    } rec_t;

    rec_t        q[$];
    int unsigned n_alloc;
    bit          m_err;
    bit          m_rv;
    bit          m_has;
    int          m_rd, m_pd, m_old;
    int unsigned m_val;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        n_alloc = 0;
        m_err = 0; m_rv = 0; m_has = 0;
        m_rd = 0; m_pd = 0; m_old = 0; m_val = 0;
    endtask

    // Applies the architectural rules for one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int sz;
        bit ret;
        int k;
        rec_t r;
        sz  = q.size();
        ret = (sz > 0) && q[0].done;
        if (cmpl_valid) begin
            k = -1;
            foreach (q[i]) if (q[i].tag == int'(cmpl_idx)) k = i;
            if (k >= 0 && !q[k].done) begin
                q[k].done  = 1;
                q[k].value = cmpl_value;
            end else begin
                m_err = 1;
            end
        end
        m_rv = ret;
        if (ret) begin
            r = q.pop_front();
            m_has = r.has_rd; m_rd = r.rd; m_pd = r.pd; m_old = r.old_pd; m_val = r.value;
        end
        if (alloc_valid && sz < DEPTH) begin
            r.tag    = int'(n_alloc % DEPTH);
            r.has_rd = alloc_has_rd && (alloc_rd != 0);
            r.rd     = int'(alloc_rd);
            r.pd     = int'(alloc_pd);
            r.old_pd = int'(alloc_old_pd);
            r.done   = 0;
            r.value  = 0;
            q.push_back(r);
            n_alloc++;
        end
    endtask

    task automatic compare_all();
        chk("count", 32'(count), q.size());
        chk("alloc_ready", 32'(alloc_ready), (q.size() < DEPTH) ? 1 : 0);
        chk("alloc_idx", 32'(alloc_idx), n_alloc % DEPTH);
        chk("cmpl_err", 32'(cmpl_err), m_err);
        chk("ret_valid", 32'(ret_valid), m_rv);
        chk("ret_has_rd", 32'(ret_has_rd), m_has);
        chk("ret_rd", 32'(ret_rd), m_rd);
        chk("ret_pd", 32'(ret_pd), m_pd);
        chk("ret_value", ret_value, m_val);
        chk("free_valid", 32'(free_valid), m_rv && m_has);
        chk("free_pd", 32'(free_pd), m_old);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_idle();
        alloc_valid = 0; cmpl_valid = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ret_valid", 32'(ret_valid), 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        compare_all();
    endtask

    task automatic set_alloc(input int rd, input int pd, input int old_pd);
        alloc_valid = 1; alloc_has_rd = 1;
        alloc_rd = AREG_W'(rd); alloc_pd = PREG_W'(pd); alloc_old_pd = PREG_W'(old_pd);
    endtask

    task automatic set_cmpl(input int idx, input int unsigned val);
        cmpl_valid = 1; cmpl_idx = IDX_W'(idx); cmpl_value = val;
    endtask

    initial begin
        int pick[$];
        @(negedge clk);

        // Single instruction round trip.
        do_reset();
        chk("t1_err_clear", 32'(cmpl_err), 0);
        set_alloc(5, 33, 5);
        chk("t1_alloc_idx", 32'(alloc_idx), 0);
        tick();
        set_idle();
        chk("t1_count", 32'(count), 1);
        set_cmpl(0, 32'h2A);
        tick();
        set_idle();
        chk("t1_no_bypass", 32'(ret_valid), 0);
        tick();
        chk("t1_ret_valid", 32'(ret_valid), 1);
        chk("t1_ret_rd", 32'(ret_rd), 5);
        chk("t1_ret_pd", 32'(ret_pd), 33);
        chk("t1_ret_value", ret_value, 32'h2A);
        chk("t1_free_pd", 32'(free_pd), 5);
        chk("t1_free_valid", 32'(free_valid), 1);

        // Out-of-order completion, in-order retire.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(10 + i, 40 + i, 20 + i);
            tick();
        end
        set_idle();
        set_cmpl(2, 32'h200); tick();
        set_cmpl(0, 32'h100); tick();
        set_cmpl(1, 32'h101); tick();
        set_idle();
        chk("t2_ret0", 32'(ret_rd), 10);
        tick();
        chk("t2_ret1", 32'(ret_rd), 11);
        chk("t2_ret1_v", 32'(ret_valid), 1);
        tick();
        chk("t2_ret2", 32'(ret_rd), 12);
        chk("t2_ret2_val", ret_value, 32'h200);
        tick();
        chk("t2_idle", 32'(ret_valid), 0);

        // Full buffer, retire while alloc held, then wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(i + 1, i + 16, i);
            tick();
        end
        chk("t3_full_ready", 32'(alloc_ready), 0);
        chk("t3_full_count", 32'(count), DEPTH);
        set_alloc(20, 50, 51);
        set_cmpl(0, 32'hABC);
        tick();
        cmpl_valid = 0;
        tick();
        chk("t3_retire_no_alloc", 32'(count), DEPTH - 1);
        tick();
        chk("t3_late_alloc", 32'(count), DEPTH);
        set_idle();
        for (int i = 1; i <= DEPTH; i++) begin
            set_cmpl(i % DEPTH, 32'h1000 + i);
            tick();
        end
        set_idle();
        for (int i = 0; i < DEPTH + 2; i++) tick();
        chk("t3_drained", 32'(count), 0);

        // x0 destination never frees.
        do_reset();
        set_alloc(0, 7, 9);
        tick();
        set_idle();
        set_cmpl(0, 32'h55);
        tick();
        set_idle();
        tick();
        chk("t4_ret_valid", 32'(ret_valid), 1);
        chk("t4_has_rd", 32'(ret_has_rd), 0);
        chk("t4_free_valid", 32'(free_valid), 0);

        // Bad completions.
        do_reset();
        set_alloc(3, 4, 5);
        tick();
        set_idle();
        set_cmpl(7, 32'hDEAD);
        tick();
        chk("t5_err_unalloc", 32'(cmpl_err), 1);
        set_cmpl(0, 32'h111); tick();
        set_cmpl(0, 32'h222); tick();
        set_idle();
        chk("t5_first_value", ret_value, 32'h111);
        do_reset();
        set_alloc(3, 4, 5);
        tick();
        set_cmpl(0, 32'h1); tick();
        set_cmpl(0, 32'h2); tick();
        set_idle();
        chk("t5_err_double", 32'(cmpl_err), 1);
        chk("t5_double_value", ret_value, 32'h1);

        // Reset with entries pending.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(i + 1, i + 1, i + 1);
            tick();
        end
        set_cmpl(0, 32'h9); tick();
        set_idle();
        do_reset();
        set_alloc(6, 6, 6);
        chk("t6_idx_after_rst", 32'(alloc_idx), 0);
        tick();
        set_idle();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            alloc_valid  = ($urandom_range(0, 99) < 60);
            alloc_has_rd = ($urandom_range(0, 9) != 0);
            alloc_rd     = AREG_W'($urandom_range(0, 31));
            alloc_pd     = PREG_W'($urandom_range(0, 63));
            alloc_old_pd = PREG_W'($urandom_range(0, 63));
            cmpl_valid   = 0;
            pick.delete();
            foreach (q[i]) if (!q[i].done) pick.push_back(q[i].tag);
            if (pick.size() > 0 && $urandom_range(0, 99) < 55) begin
                set_cmpl(pick[$urandom_range(0, pick.size() - 1)], $urandom);
            end else if ($urandom_range(0, 199) == 0) begin
                set_cmpl(int'($urandom_range(0, DEPTH - 1)), $urandom);
            end
            tick();
        end
        set_idle();
        for (int i = 0; i < DEPTH + 2; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
